// File: rtl/ps2_key_queue.sv
// rtl/ps2_key_queue.sv - PS/2 receiver, scancode decoder and game-code FIFO
module ps2_key_queue #(
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int REPEAT_SUPPRESS = 1,
    parameter int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PS2_CLK,
    input  logic             PS2_DAT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_letter,
    output logic [CNT_W-1:0] fifo_count,
    output logic             key_held,
    output logic             overflow,
    output logic             frame_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

    // Synchroniser and edge-detect registers; idle-high so reset never fakes an edge.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic ps2_fall;

    // Receiver state
    rx_state_t         rx_state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic              byte_strobe_q;
    logic              frame_err_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              rx_timeout;

    // Decoder state
    dec_state_t        dec_state_q;
    logic [4:0]        held_code_q;
    logic              key_held_q;
    logic              push_q;
    logic [4:0]        push_data_q;
    logic              is_ext;
    logic              is_break;
    logic              is_prefix;
    logic [5:0]        map_res;
    logic              map_hit;
    logic [4:0]        map_val;
    logic              same_held;

    // FIFO state
    logic [4:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q;
    logic              fifo_full;
    logic              do_pop;
    logic              do_push;

    // Scancode to game-code lookup; bit 5 flags a mapped code.
    function automatic logic [5:0] map_code(input logic [7:0] sc, input logic ext);
        logic [5:0] r;
        r = 6'd0;
        if (ext) begin
            if (sc == 8'h5A) r = {1'b1, 5'd26};
        end else begin
            case (sc)
                8'h1C: r = {1'b1, 5'd0};
                8'h32: r = {1'b1, 5'd1};
                8'h21: r = {1'b1, 5'd2};
                8'h23: r = {1'b1, 5'd3};
                8'h24: r = {1'b1, 5'd4};
                8'h2B: r = {1'b1, 5'd5};
                8'h34: r = {1'b1, 5'd6};
                8'h33: r = {1'b1, 5'd7};
                8'h43: r = {1'b1, 5'd8};
                8'h3B: r = {1'b1, 5'd9};
                8'h42: r = {1'b1, 5'd10};
                8'h4B: r = {1'b1, 5'd11};
                8'h3A: r = {1'b1, 5'd12};
                8'h31: r = {1'b1, 5'd13};
                8'h44: r = {1'b1, 5'd14};
                8'h4D: r = {1'b1, 5'd15};
                8'h15: r = {1'b1, 5'd16};
                8'h2D: r = {1'b1, 5'd17};
                8'h1B: r = {1'b1, 5'd18};
                8'h2C: r = {1'b1, 5'd19};
                8'h3C: r = {1'b1, 5'd20};
                8'h2A: r = {1'b1, 5'd21};
                8'h1D: r = {1'b1, 5'd22};
                8'h22: r = {1'b1, 5'd23};
                8'h35: r = {1'b1, 5'd24};
                8'h1A: r = {1'b1, 5'd25};
                8'h5A: r = {1'b1, 5'd26};
                8'h66: r = {1'b1, 5'd27};
                default: r = 6'd0;
            endcase
        end
        return r;
    endfunction

    // Two-flop synchronisers plus the previous synchronised clock for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_DAT;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign ps2_fall   = clk_prev_q & ~clk_s2_q;
    assign rx_timeout = (rx_state_q != RX_IDLE) && !ps2_fall &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Idle-time counter: cleared on every PS/2 falling edge and while idle, saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (ps2_fall || rx_state_q == RX_IDLE) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Frame receiver: start, 8 data bits LSB first, odd parity, stop; strobes are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q    <= RX_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            parity_q      <= 1'b0;
            byte_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            byte_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
            if (rx_timeout) begin
                rx_state_q  <= RX_IDLE;
                frame_err_q <= 1'b1;
            end else if (ps2_fall) begin
                case (rx_state_q)
                    RX_IDLE: begin
                        if (!dat_s2_q) begin
                            rx_state_q <= RX_DATA;
                            bit_cnt_q  <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity_q   <= dat_s2_q;
                        rx_state_q <= RX_STOP;
                    end
                    default: begin
                        rx_state_q <= RX_IDLE;
                        if (dat_s2_q && (^{shift_q, parity_q}))
                            byte_strobe_q <= 1'b1;
                        else
                            frame_err_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Classify the received byte against the current prefix state.
    always_comb begin
        is_ext    = (dec_state_q == D_EXT) || (dec_state_q == D_EXT_BRK);
        is_break  = (dec_state_q == D_BRK) || (dec_state_q == D_EXT_BRK);
        is_prefix = ((shift_q == 8'hF0) && (dec_state_q == D_IDLE || dec_state_q == D_EXT)) ||
                    ((shift_q == 8'hE0) && (dec_state_q == D_IDLE));
        map_res   = map_code(shift_q, is_ext);
        map_hit   = map_res[5];
        map_val   = map_res[4:0];
        same_held = key_held_q && (held_code_q == map_val);
    end

    // Prefix tracker, repeat filter and held-key tracking; issues one push per accepted make.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_state_q <= D_IDLE;
            held_code_q <= 5'd0;
            key_held_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= 5'd0;
        end else begin
            push_q <= 1'b0;
            if (byte_strobe_q) begin
                if (is_prefix) begin
                    if (shift_q == 8'hE0)
                        dec_state_q <= D_EXT;
                    else if (dec_state_q == D_EXT)
                        dec_state_q <= D_EXT_BRK;
                    else
                        dec_state_q <= D_BRK;
                end else begin
                    dec_state_q <= D_IDLE;
                    if (map_hit) begin
                        if (is_break) begin
                            if (same_held) key_held_q <= 1'b0;
                        end else if (!(same_held && REPEAT_SUPPRESS != 0)) begin
                            push_q      <= 1'b1;
                            push_data_q <= map_val;
                            held_code_q <= map_val;
                            key_held_q  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign do_pop    = out_valid && out_ready;
    assign do_push   = push_q && (!fifo_full || do_pop);

    // Occupancy next-state; a simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (!do_push && do_pop)
            count_d = count_q - 1'b1;
    end

    // FIFO storage, pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_q && !do_push) overflow_q <= 1'b1;
            count_q <= count_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_letter = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign key_held   = key_held_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_queue.sv
// tb/tb_ps2_key_queue.sv - directed scoreboard bench for ps2_key_queue
module tb_ps2_key_queue;

    localparam int DEPTH = 4;
    localparam int TO    = 200;
    localparam int HALF  = 10;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          PS2_CLK = 1'b1;
    logic          PS2_DAT = 1'b1;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [4:0]    out_letter;
    logic [CW-1:0] fifo_count;
    logic          key_held;
    logic          overflow;
    logic          frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int err_pulses = 0;
    int err_cycles = 0;
    logic err_prev = 1'b0;
    int exp_q[$];
    int lat;
    int e0;

    ps2_key_queue #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TO),
        .REPEAT_SUPPRESS(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PS2_CLK(PS2_CLK),
        .PS2_DAT(PS2_DAT),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_letter(out_letter),
        .fifo_count(fifo_count),
        .key_held(key_held),
        .overflow(overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_cycles++;
        if (frame_err && !err_prev) err_pulses++;
        err_prev = frame_err;
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        PS2_DAT = b;
        wait_cycles(HALF);
        PS2_CLK = 1'b0;
        wait_cycles(HALF);
        PS2_CLK = 1'b1;
    endtask

    // Full frame; lat = clk edges from stop-bit falling edge to out_valid (-1 if never).
    task automatic send_frame(input logic [7:0] b, input bit good_par, output int l);
        logic par;
        par = ~(^b);
        if (!good_par) par = ~par;
        l = -1;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        @(negedge clk);
        PS2_DAT = 1'b1;
        wait_cycles(HALF);
        PS2_CLK = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (out_valid && l < 0) l = i;
        end
        PS2_CLK = 1'b1;
        wait_cycles(2 * HALF);
    endtask

    task automatic send(input logic [7:0] b);
        int l;
        send_frame(b, 1'b1, l);
    endtask

    task automatic partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    endtask

    task automatic pop_check(input string tag);
        int n;
        int expv;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, int'(out_valid), 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            expv = exp_q.pop_front();
            check({tag, "_letter"}, int'(out_letter), expv);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        wait_cycles(5);
        check("rst_valid", int'(out_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_letter", int'(out_letter), 0);
        reset = 1'b1;
        wait_cycles(5);

        // single 1C frame, consumer stalled
        exp_q.push_back(0);
        send_frame(8'h1C, 1'b1, lat);
        check("t1_latency", lat, 5);
        check("t1_letter", int'(out_letter), exp_q[0]);
        check("t1_count", int'(fifo_count), 1);
        check("t1_held", int'(key_held), 1);
        pop_check("t1_pop");
        wait_cycles(1);
        check("t1_count_after", int'(fifo_count), 0);
        send(8'hF0); send(8'h1C);
        check("t1_release", int'(key_held), 0);

        // typematic repeat suppression
        exp_q.push_back(0);
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        check("t2_held_brk", int'(key_held), 0);
        exp_q.push_back(0);
        send(8'h1C);
        check("t2_held_mk", int'(key_held), 1);
        check("t2_count", int'(fifo_count), 2);
        pop_check("t2_pop0");
        pop_check("t2_pop1");
        send(8'hF0); send(8'h1C);

        // extended codes
        exp_q.push_back(26);
        send(8'hE0); send(8'h5A);
        pop_check("t3_kpenter");
        send(8'hE0); send(8'hF0); send(8'h5A);
        check("t3_ext_release", int'(key_held), 0);
        send(8'hE0); send(8'h75);
        check("t3_unmapped_count", int'(fifo_count), 0);
        check("t3_unmapped_held", int'(key_held), 0);
        exp_q.push_back(0);
        send(8'h1C);
        pop_check("t3_back_idle");
        send(8'hF0); send(8'h1C);

        // parity error
        e0 = err_pulses;
        send_frame(8'h5A, 1'b0, lat);
        check("t4_err_pulse", err_pulses, e0 + 1);
        check("t4_count", int'(fifo_count), 0);
        exp_q.push_back(1);
        send(8'h32);
        pop_check("t4_after_err");
        send(8'hF0); send(8'h32);

        // overflow with stalled consumer
        begin
            logic [7:0] codes [5];
            codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21;
            codes[3] = 8'h23; codes[4] = 8'h24;
            for (int i = 0; i < 5; i++) begin
                if (i < DEPTH) exp_q.push_back(i);
                send(codes[i]);
            end
        end
        check("t5_count_full", int'(fifo_count), DEPTH);
        check("t5_overflow", int'(overflow), 1);
        check("t5_held", int'(key_held), 1);
        for (int i = 0; i < DEPTH; i++) pop_check("t5_pop");
        wait_cycles(1);
        check("t5_count_empty", int'(fifo_count), 0);
        check("t5_overflow_sticky", int'(overflow), 1);
        send(8'hF0); send(8'h24);

        // timeout on a partial frame
        e0 = err_pulses;
        partial(8'h66, 4);
        wait_cycles(TO + 20);
        check("t6_timeout_err", err_pulses, e0 + 1);
        exp_q.push_back(27);
        send(8'h66);
        pop_check("t6_backspace");

        // reset during a frame
        exp_q.push_back(0);
        send(8'h1C);
        check("t7_count_pre", int'(fifo_count), 1);
        partial(8'h21, 3);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        wait_cycles(2);
        check("t7_valid", int'(out_valid), 0);
        check("t7_count", int'(fifo_count), 0);
        check("t7_held", int'(key_held), 0);
        check("t7_ovf", int'(overflow), 0);
        check("t7_letter", int'(out_letter), 0);
        reset = 1'b1;
        wait_cycles(5);
        exp_q.push_back(2);
        send(8'h21);
        pop_check("t7_after_reset");

        check("err_single_cycle", err_cycles, err_pulses);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
